mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory (request/valid handshake, 8-bit word address, 32-bit data, 4-bit byte mask) between the core's instruction-fetch port and data load/store port.
- Sits between core and a unified memory top.
- Fixed data-over-instruction priority, with a streak limit so fetch never starves.
- Registers each granted transaction, holds it on the memory port until memory valid or timeout, then returns a one-cycle valid to the owner.

Parameters:
- ADDR_W, 8, word address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, max consecutive data grants while a fetch is pending (>=1)
- TIMEOUT, 64, cycles to wait for mem_valid before aborting (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- i_request  in  1  fetch request, level, held until i_valid
- i_we_re  in  1  fetch direction (1 write, 0 read)
- i_mask  in  4  fetch byte mask
- i_address  in  ADDR_W  fetch word address
- i_data_in  in  DATA_W  fetch write data (program load)
- i_valid  out  1  fetch done, one-cycle pulse
- i_data_out  out  DATA_W  fetch read data
- d_request  in  1  data request, level, held until d_valid
- d_we_re  in  1  data direction (1 store, 0 load)
- d_mask  in  4  store byte mask
- d_load  in  1  load qualifier
- d_address  in  ADDR_W  data word address
- d_data_in  in  DATA_W  store data
- d_valid  out  1  data done, one-cycle pulse
- d_data_out  out  DATA_W  load data
- mem_request  out  1  memory request
- mem_we_re  out  1  memory direction
- mem_mask  out  4  memory byte mask
- mem_load  out  1  load qualifier to memory (0 for fetch)
- mem_address  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_valid  in  1  memory completion
- mem_data_out  in  DATA_W  memory read data
- err  out  1  timeout abort, pulses with the owner's valid

Behaviour:
- Reset (rst=0, async):
  - state IDLE; all outputs 0; streak and timer 0.
  - Mid-transaction reset drops mem_request immediately; no valid is issued for the aborted transaction.
- States:
  - IDLE: arbitrate.
  - BUSY_I / BUSY_D: mem_request=1, command registers held stable.
  - RESP: owner valid=1 for exactly one cycle.
- IDLE arbitration, evaluated every cycle:
  - grant D if d_request && (!i_request || streak<MAX_D_STREAK);
  - else grant I if i_request;
  - else stay in IDLE.
  - On grant, capture the owner's we_re/mask/load/address/data into the mem_* registers and move to BUSY_x. mem_request rises the next cycle (one-cycle arbitration latency).
- Streak counter:
  - increments on a D grant while i_request=1;
  - clears on any I grant, or in any IDLE cycle with i_request=0;
  - saturates at MAX_D_STREAK.
- BUSY_x:
  - Timer counts from 0.
  - On mem_valid: latch mem_data_out into the owner's data_out (only if the captured we_re=0; writes leave data_out unchanged), deassert mem_request, go to RESP.
  - If the timer reaches TIMEOUT-1 without mem_valid: deassert mem_request, set the owner's data_out to 0, go to RESP with err=1.
- RESP: pulse the owner's valid (plus err if it timed out), then return to IDLE.
- Timing:
  - Transaction cost is 1 + N + 1 cycles for a memory latency of N.
  - The requester deasserts request in its valid cycle; the next arbitration happens in the following IDLE cycle.
- Idle data outputs: i_data_out and d_data_out hold their last value until overwritten.
- Ignored inputs: mem_valid in IDLE or RESP. Requester field changes during BUSY have no effect on the mem_* outputs.
- Mutual exclusion: i_valid and d_valid are never high in the same cycle; at most one transaction is outstanding.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY_I, BUSY_D, RESP};
  - owner enum {OWN_I, OWN_D};
  - constants WE_WRITE=1, WE_READ=0;
  - timer width function clog2(TIMEOUT).
- Sub-module:
  - mem_arb_timeout, a loadable down-counter with an expire flag, reusable by other memory controllers.
  - Arbitration and FSM stay in the top module.

Test Plan:
- Only i_request, address 0x05, memory returns 0xDEADBEEF after 2 cycles -> mem_request high cycles 1–3, i_valid pulse at cycle 4, i_data_out=0xDEADBEEF, err=0.
- i_request and d_request rise together, d_we_re=1, mask 4'b0011, data 0x1234 -> data granted first, mem_mask=0011, mem_we_re=1, d_valid before any fetch grant, d_data_out unchanged.
- d_request held continuously across back-to-back transactions, i_request held, MAX_D_STREAK=4 -> exactly 4 data grants, then 1 fetch grant, then data resumes.
- mem_valid never returns, TIMEOUT=64 -> mem_request drops after 64 BUSY cycles, owner valid and err pulse together, data_out=0.
- rst pulled low during BUSY_D -> mem_request=0 immediately, no d_valid; after release a new fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory port arbiter and its timeout counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  localparam logic WE_WRITE = 1'b1;
  localparam logic WE_READ  = 1'b0;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and unified memory port.
// slave  : the arbiter's view (serves the core, drives the memory).
// master : the surrounding core + memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              i_request;
  logic              i_we_re;
  logic [3:0]        i_mask;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_data_in;
  logic              i_valid;
  logic [DATA_W-1:0] i_data_out;

  logic              d_request;
  logic              d_we_re;
  logic [3:0]        d_mask;
  logic              d_load;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_data_in;
  logic              d_valid;
  logic [DATA_W-1:0] d_data_out;

  logic              mem_request;
  logic              mem_we_re;
  logic [3:0]        mem_mask;
  logic              mem_load;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_data_out;
  logic              err;

  modport slave (
    input  i_request, i_we_re, i_mask, i_address, i_data_in,
    output i_valid, i_data_out,
    input  d_request, d_we_re, d_mask, d_load, d_address, d_data_in,
    output d_valid, d_data_out,
    output mem_request, mem_we_re, mem_mask, mem_load, mem_address, mem_data_in,
    input  mem_valid, mem_data_out,
    output err
  );

  modport master (
    output i_request, i_we_re, i_mask, i_address, i_data_in,
    input  i_valid, i_data_out,
    output d_request, d_we_re, d_mask, d_load, d_address, d_data_in,
    input  d_valid, d_data_out,
    input  mem_request, mem_we_re, mem_mask, mem_load, mem_address, mem_data_in,
    output mem_valid, mem_data_out,
    input  err
  );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Loadable down-counter with a terminal-count expire flag. Load with N-1 to
// expire on the Nth enabled cycle after the load.
module mem_arb_timeout #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;

  // Reload on request, otherwise count down while enabled and park at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports.
// Data has priority, bounded by a streak limit so a pending fetch is served.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | arbitrate; capture the winner's command into mem_* registers
//   BUSY_I | fetch command on the memory port, waiting for mem_valid/timeout
//   BUSY_D | data command on the memory port, waiting for mem_valid/timeout
//   RESP   | one-cycle valid (and err on timeout) back to the owner
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int                 TMR_W    = clog2(TIMEOUT);
  localparam int                 STRK_W   = clog2(MAX_D_STREAK + 1);
  localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [STRK_W-1:0]  STRK_MAX = STRK_W'(MAX_D_STREAK);

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  logic [STRK_W-1:0] streak_q;

  logic              mem_request_q;
  logic              mem_we_re_q;
  logic [3:0]        mem_mask_q;
  logic              mem_load_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_data_in_q;
  logic              i_valid_q;
  logic              d_valid_q;
  logic [DATA_W-1:0] i_data_out_q;
  logic [DATA_W-1:0] d_data_out_q;
  logic              err_q;

  logic grant_d;
  logic grant_i;
  logic busy;
  logic tmr_expire;

  // The streak check is what lets a waiting fetch through; streak_q can only
  // reach STRK_MAX, never pass it, because a D grant needs streak_q < STRK_MAX
  // whenever a fetch is pending.
  assign grant_d = (state_q == IDLE) && bus.d_request &&
                   (!bus.i_request || (streak_q < STRK_MAX));
  assign grant_i = (state_q == IDLE) && !grant_d && bus.i_request;
  assign busy    = (state_q == BUSY_I) || (state_q == BUSY_D);

  mem_arb_timeout #(
    .CNT_W (TMR_W)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .load_i     (grant_d || grant_i),
    .en_i       (busy),
    .load_val_i (TMR_LOAD),
    .expire_o   (tmr_expire)
  );

  // Arbitration, command capture, completion and response sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      owner_q       <= OWN_I;
      streak_q      <= '0;
      mem_request_q <= 1'b0;
      mem_we_re_q   <= 1'b0;
      mem_mask_q    <= '0;
      mem_load_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      i_valid_q     <= 1'b0;
      d_valid_q     <= 1'b0;
      i_data_out_q  <= '0;
      d_data_out_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q       <= BUSY_D;
            owner_q       <= OWN_D;
            mem_request_q <= 1'b1;
            mem_we_re_q   <= bus.d_we_re;
            mem_mask_q    <= bus.d_mask;
            mem_load_q    <= bus.d_load;
            mem_address_q <= bus.d_address;
            mem_data_in_q <= bus.d_data_in;
            streak_q      <= bus.i_request ? streak_q + 1'b1 : '0;
          end else if (grant_i) begin
            state_q       <= BUSY_I;
            owner_q       <= OWN_I;
            mem_request_q <= 1'b1;
            mem_we_re_q   <= bus.i_we_re;
            mem_mask_q    <= bus.i_mask;
            mem_load_q    <= 1'b0;
            mem_address_q <= bus.i_address;
            mem_data_in_q <= bus.i_data_in;
            streak_q      <= '0;
          end else if (!bus.i_request) begin
            streak_q <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // A response arriving on the final timer cycle still counts.
          if (bus.mem_valid) begin
            mem_request_q <= 1'b0;
            state_q       <= RESP;
            err_q         <= 1'b0;
            if (owner_q == OWN_D) begin
              d_valid_q <= 1'b1;
              if (mem_we_re_q == WE_READ) d_data_out_q <= bus.mem_data_out;
            end else begin
              i_valid_q <= 1'b1;
              if (mem_we_re_q == WE_READ) i_data_out_q <= bus.mem_data_out;
            end
          end else if (tmr_expire) begin
            mem_request_q <= 1'b0;
            state_q       <= RESP;
            err_q         <= 1'b1;
            if (owner_q == OWN_D) begin
              d_valid_q    <= 1'b1;
              d_data_out_q <= '0;
            end else begin
              i_valid_q    <= 1'b1;
              i_data_out_q <= '0;
            end
          end
        end
        RESP: begin
          i_valid_q <= 1'b0;
          d_valid_q <= 1'b0;
          err_q     <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_request = mem_request_q;
  assign bus.mem_we_re   = mem_we_re_q;
  assign bus.mem_mask    = mem_mask_q;
  assign bus.mem_load    = mem_load_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.i_valid     = i_valid_q;
  assign bus.i_data_out  = i_data_out_q;
  assign bus.d_valid     = d_valid_q;
  assign bus.d_data_out  = d_data_out_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters, memory model and
// monitors run in one negedge process; tests push requests plus expected
// grants and responses into queues.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus();

  mem_port_arbiter #(
    .ADDR_W       (8),
    .DATA_W       (32),
    .MAX_D_STREAK (4),
    .TIMEOUT      (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [3:0]  mask;
    logic        load;
    logic [7:0]  addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;   // cycles from request to valid; 0 = not checked
  } rsp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [5:0]  cmd;   // {we, mask, load}
    logic [31:0] data;
  } gnt_t;

  req_t iq[$];
  req_t dq[$];
  rsp_t i_exp[$];
  rsp_t d_exp[$];
  gnt_t g_exp[$];

  logic [31:0] mem [256];
  logic [31:0] last_i, last_d;

  int n_checks, n_errors;
  int cyc;
  int i_start, d_start;
  logic i_act, d_act;
  logic mem_en, spur_en;
  int mem_lat_lo, mem_lat_hi, mlat, mcnt;
  int busy_cnt, exp_busy;
  logic mreq_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {8'h5A, a, ~a, 8'hC3};
  endfunction

  task automatic push_g(input logic [7:0] a, input logic we, input logic [3:0] m,
                        input logic ld, input logic [31:0] wd);
    gnt_t g;
    g.addr = a; g.cmd = {we, m, ld}; g.data = wd;
    g_exp.push_back(g);
  endtask

  task automatic push_i_rd(input logic [7:0] a, input logic [31:0] e, input logic er, input int lat);
    req_t r; rsp_t s;
    r.we = 1'b0; r.mask = 4'hF; r.load = 1'b0; r.addr = a; r.data = {4{a}};
    s.data = e; s.err = er; s.lat = lat;
    iq.push_back(r); i_exp.push_back(s);
    last_i = e;
  endtask

  task automatic push_d_rd(input logic [7:0] a, input logic [31:0] e, input logic er, input int lat);
    req_t r; rsp_t s;
    r.we = 1'b0; r.mask = 4'hF; r.load = 1'b1; r.addr = a; r.data = {4{a}};
    s.data = e; s.err = er; s.lat = lat;
    dq.push_back(r); d_exp.push_back(s);
    last_d = e;
  endtask

  task automatic push_d_wr(input logic [7:0] a, input logic [3:0] m, input logic [31:0] wd, input int lat);
    req_t r; rsp_t s;
    r.we = 1'b1; r.mask = m; r.load = 1'b0; r.addr = a; r.data = wd;
    s.data = last_d; s.err = 1'b0; s.lat = lat;
    dq.push_back(r); d_exp.push_back(s);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int pend;
    pend = 1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      pend = iq.size() + dq.size() + i_exp.size() + d_exp.size() + g_exp.size()
           + int'(i_act) + int'(d_act) + int'(bus.mem_request);
      if (pend == 0) break;
    end
    chk(tag, 64'(pend), 64'd0);
  endtask

  // Requesters, memory model and output monitors, evaluated on every negedge.
  initial begin : env
    rsp_t e;
    gnt_t g;
    req_t r;
    bus.i_request = 0; bus.i_we_re = 0; bus.i_mask = 0; bus.i_address = 0; bus.i_data_in = 0;
    bus.d_request = 0; bus.d_we_re = 0; bus.d_mask = 0; bus.d_load = 0; bus.d_address = 0;
    bus.d_data_in = 0; bus.mem_valid = 0; bus.mem_data_out = 0;
    i_act = 0; d_act = 0; mcnt = 0; mlat = 0; busy_cnt = 0; mreq_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.i_request = 0; bus.d_request = 0; i_act = 0; d_act = 0;
        bus.mem_valid = 0; mcnt = 0; busy_cnt = 0; mreq_prev = 0;
      end else begin
        if (bus.i_valid || bus.d_valid)
          chk("valid_excl", 64'(bus.i_valid & bus.d_valid), 64'd0);
        if (bus.err && !bus.i_valid && !bus.d_valid)
          chk("err_alone", 64'(bus.err), 64'd0);
        if (bus.i_valid) begin
          if (i_act && i_exp.size() > 0) begin
            e = i_exp.pop_front();
            chk("i_data", 64'(bus.i_data_out), 64'(e.data));
            chk("i_err", 64'(bus.err), 64'(e.err));
            if (e.lat != 0) chk("i_lat", 64'(cyc - i_start), 64'(e.lat));
            i_act = 0; bus.i_request = 0;
          end else chk("i_spurious", 64'(bus.i_valid), 64'(i_act));
        end
        if (bus.d_valid) begin
          if (d_act && d_exp.size() > 0) begin
            e = d_exp.pop_front();
            chk("d_data", 64'(bus.d_data_out), 64'(e.data));
            chk("d_err", 64'(bus.err), 64'(e.err));
            if (e.lat != 0) chk("d_lat", 64'(cyc - d_start), 64'(e.lat));
            d_act = 0; bus.d_request = 0;
          end else chk("d_spurious", 64'(bus.d_valid), 64'(d_act));
        end
        if (bus.mem_request && !mreq_prev && g_exp.size() > 0) begin
          g = g_exp.pop_front();
          chk("gnt_addr", 64'(bus.mem_address), 64'(g.addr));
          chk("gnt_cmd", 64'({bus.mem_we_re, bus.mem_mask, bus.mem_load}), 64'(g.cmd));
          chk("gnt_wdata", 64'(bus.mem_data_in), 64'(g.data));
        end
        if (bus.mem_request) busy_cnt++;
        else if (mreq_prev) begin
          if (exp_busy != 0) chk("busy_len", 64'(busy_cnt), 64'(exp_busy));
          busy_cnt = 0;
        end
        mreq_prev = bus.mem_request;
        if (bus.mem_request) begin
          if (mem_en) begin
            if (mcnt == 0) mlat = int'($urandom_range(mem_lat_hi, mem_lat_lo));
            if (mcnt == mlat) begin
              bus.mem_valid = 1;
              bus.mem_data_out = mem[bus.mem_address];
              if (bus.mem_we_re)
                for (int b = 0; b < 4; b++)
                  if (bus.mem_mask[b]) mem[bus.mem_address][8*b +: 8] = bus.mem_data_in[8*b +: 8];
            end else begin
              bus.mem_valid = 0;
              bus.mem_data_out = $urandom;
            end
            mcnt++;
          end else begin
            bus.mem_valid = 0;
            bus.mem_data_out = $urandom;
          end
        end else begin
          mcnt = 0;
          bus.mem_valid = spur_en ? 1'($urandom_range(1, 0)) : 1'b0;
          bus.mem_data_out = $urandom;
        end
        if (!i_act && iq.size() > 0) begin
          r = iq.pop_front();
          bus.i_we_re = r.we; bus.i_mask = r.mask; bus.i_address = r.addr; bus.i_data_in = r.data;
          bus.i_request = 1; i_act = 1; i_start = cyc;
        end
        if (!d_act && dq.size() > 0) begin
          r = dq.pop_front();
          bus.d_we_re = r.we; bus.d_mask = r.mask; bus.d_load = r.load;
          bus.d_address = r.addr; bus.d_data_in = r.data;
          bus.d_request = 1; d_act = 1; d_start = cyc;
        end
      end
    end
  end

  initial begin : main
    n_checks = 0; n_errors = 0; cyc = 0;
    last_i = 0; last_d = 0;
    mem_en = 1; spur_en = 0; mem_lat_lo = 2; mem_lat_hi = 2; exp_busy = 0;
    for (int a = 0; a < 256; a++) mem[a] = pat(8'(a));
    mem[8'h05] = 32'hDEADBEEF;
    mem[8'h10] = 32'hCAFEF00D;
    mem[8'h20] = 32'hAABBCCDD;
    rst = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_mem_request", 64'(bus.mem_request), 64'd0);
    chk("rst_valids", 64'({bus.i_valid, bus.d_valid, bus.err}), 64'd0);
    chk("rst_i_data", 64'(bus.i_data_out), 64'd0);
    chk("rst_d_data", 64'(bus.d_data_out), 64'd0);
    chk("rst_mem_cmd", 64'({bus.mem_we_re, bus.mem_mask, bus.mem_load, bus.mem_address}), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_data_in), 64'd0);
    rst = 1;
    repeat (2) @(posedge clk); #1;

    // Lone fetch, memory latency 2.
    exp_busy = 3;
    push_g(8'h05, 1'b0, 4'hF, 1'b0, {4{8'h05}});
    push_i_rd(8'h05, 32'hDEADBEEF, 1'b0, 4);
    wait_idle("t1_drain", 50);
    chk("t1_i_data_hold", 64'(bus.i_data_out), 64'h0000_0000_DEAD_BEEF);

    push_g(8'h10, 1'b0, 4'hF, 1'b1, {4{8'h10}});
    push_d_rd(8'h10, 32'hCAFEF00D, 1'b0, 4);
    wait_idle("t1b_drain", 50);

    // Simultaneous requests: data store wins, fetch follows.
    push_g(8'h20, 1'b1, 4'b0011, 1'b0, 32'h0000_1234);
    push_g(8'h06, 1'b0, 4'hF, 1'b0, {4{8'h06}});
    push_d_wr(8'h20, 4'b0011, 32'h0000_1234, 4);
    push_i_rd(8'h06, pat(8'h06), 1'b0, 9);
    wait_idle("t2_drain", 60);
    push_g(8'h20, 1'b0, 4'hF, 1'b1, {4{8'h20}});
    push_d_rd(8'h20, 32'hAABB1234, 1'b0, 4);
    wait_idle("t2b_drain", 50);

    // Data streak limit with a fetch held pending.
    mem_lat_lo = 1; mem_lat_hi = 1; exp_busy = 2;
    for (int k = 0; k < 4; k++) push_g(8'(8'h30 + k), 1'b0, 4'hF, 1'b1, {4{8'(8'h30 + k)}});
    push_g(8'h40, 1'b0, 4'hF, 1'b0, {4{8'h40}});
    push_g(8'h34, 1'b0, 4'hF, 1'b1, {4{8'h34}});
    push_g(8'h35, 1'b0, 4'hF, 1'b1, {4{8'h35}});
    push_i_rd(8'h40, pat(8'h40), 1'b0, 19);
    for (int k = 0; k < 6; k++) push_d_rd(8'(8'h30 + k), pat(8'(8'h30 + k)), 1'b0, (k == 0) ? 3 : 0);
    wait_idle("t3_drain", 100);

    // Memory never answers: abort after 64 busy cycles.
    mem_en = 0; exp_busy = 64;
    push_g(8'h50, 1'b0, 4'hF, 1'b1, {4{8'h50}});
    push_d_rd(8'h50, 32'h0, 1'b1, 65);
    wait_idle("t4_drain", 120);
    chk("t4_d_zero_hold", 64'(bus.d_data_out), 64'd0);

    // Answer on the last allowed cycle still completes normally.
    mem_en = 1; mem_lat_lo = 63; mem_lat_hi = 63;
    push_g(8'h51, 1'b0, 4'hF, 1'b0, {4{8'h51}});
    push_i_rd(8'h51, pat(8'h51), 1'b0, 65);
    wait_idle("t4b_drain", 120);

    // Reset while a data transaction is outstanding.
    mem_en = 0; exp_busy = 0;
    push_g(8'h60, 1'b0, 4'hF, 1'b1, {4{8'h60}});
    dq.push_back('{we: 1'b0, mask: 4'hF, load: 1'b1, addr: 8'h60, data: {4{8'h60}}});
    for (int k = 0; k < 10 && !bus.mem_request; k++) begin @(posedge clk); #1; end
    chk("t5_busy_d", 64'(bus.mem_request), 64'd1);
    repeat (3) @(posedge clk); #1;
    #1 rst = 0;
    #1;
    chk("t5_mem_request_drop", 64'(bus.mem_request), 64'd0);
    chk("t5_no_valid", 64'({bus.i_valid, bus.d_valid, bus.err}), 64'd0);
    chk("t5_i_data_rst", 64'(bus.i_data_out), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1;
    mem_en = 1; mem_lat_lo = 2; mem_lat_hi = 2;
    repeat (10) @(posedge clk); #1;
    exp_busy = 3;
    push_g(8'h07, 1'b0, 4'hF, 1'b0, {4{8'h07}});
    push_i_rd(8'h07, pat(8'h07), 1'b0, 4);
    wait_idle("t5_drain", 50);

    // Mixed traffic, random latency, stray mem_valid outside BUSY.
    exp_busy = 0; spur_en = 1; mem_lat_lo = 0; mem_lat_hi = 4;
    for (int k = 0; k < 12; k++) begin
      logic [7:0] a;
      a = 8'($urandom_range(255, 128));
      push_i_rd(a, mem[a], 1'b0, 0);
      if (k % 3 == 0) push_d_wr(8'(8'h70 + k), 4'($urandom_range(15, 1)), $urandom, 0);
      else begin
        a = 8'($urandom_range(255, 128));
        push_d_rd(a, mem[a], 1'b0, 0);
      end
    end
    wait_idle("t6_drain", 1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
